riscv_dmem_ahb_responder: RTL and testbench

Responder end of the core data-memory request interface. Accepts the one-cycle dmem_req pulses from the load/store unit and returns per-request dmem_ack with dmem_q, dmem_misaligned and dmem_page_fault. Buffers requests in a small in-order queue because the LSU does not wait for ack. Executes each aligned request as a single AHB3-Lite transfer and sits between the LSU and the data bus.

---
 rtl/riscv_mpsoc_pkg.sv | 44 ++++
 rtl/riscv_dmem_queue.sv | 54 +++++
 rtl/riscv_dmem_ahb_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_riscv_dmem_ahb_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mpsoc_pkg.sv
// Shared constants and types for the RISC-V MPSoC data-memory path.
// Holds the access-size encoding, AHB3-Lite field values and the dmem
// responder state type, plus the alignment rule used by the responder.
package riscv_mpsoc_pkg;

    // Access size encoding used by the LSU and mapped 1:1 onto HSIZE
    localparam logic [2:0] BYTE       = 3'b000;
    localparam logic [2:0] HWORD      = 3'b001;
    localparam logic [2:0] WORD       = 3'b010;
    localparam logic [2:0] DWORD      = 3'b011;
    localparam logic [2:0] UNDEF_SIZE = 3'b111;

    // AHB3-Lite field values
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0001;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Responder FSM states
    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_ADDR = 2'b01,
        DMEM_DATA = 2'b10
    } dmem_state_e;

    // True when the access cannot be issued as one naturally aligned transfer
    function automatic logic dmem_misaligned_f(input logic [2:0] size,
                                               input logic [2:0] adr_lo,
                                               input logic       xlen32);
        logic mis_s;
        case (size)
            BYTE:       mis_s = 1'b0;
            HWORD:      mis_s = adr_lo[0];
            WORD:       mis_s = |adr_lo[1:0];
            DWORD:      mis_s = (|adr_lo) | xlen32;
            UNDEF_SIZE: mis_s = 1'b1;
            default:    mis_s = 1'b1;
        endcase
        return mis_s;
    endfunction

endpackage

// File: rtl/riscv_dmem_queue.sv
// In-order request FIFO for the dmem responder.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// a push into a full queue is accepted only when a pop happens on the same edge.
module riscv_dmem_queue
    import riscv_mpsoc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update; reset empties the queue and clears entries
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_ahb_responder.sv
// Responder for the core data-memory request interface.
// Queues one-cycle LSU requests in order, rejects misaligned ones without a
// bus access, and runs each aligned one as a single AHB3-Lite transfer with
// non-overlapped address and data phases.
// Optional build macro RISCV_DMEM_EARLY_STORE_ACK_EN: aligned stores ack when
// issued, and a later bus error on such a store sets sticky dmem_store_err.
module riscv_dmem_ahb_responder
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  logic [2:0]      dmem_size,
    output logic            dmem_ack,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault,
    output logic            dmem_busy,
    output logic            dmem_overflow,
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
    output logic            dmem_store_err,
`endif
    output logic [XLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam int QW = 2 * XLEN + 4;

    // Queue interface
    logic [QW-1:0]   q_push_data_s;
    logic [QW-1:0]   q_head_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic            q_pop_s;
    logic [XLEN-1:0] head_adr_s;
    logic [XLEN-1:0] head_d_s;
    logic            head_we_s;
    logic [2:0]      head_size_s;
    logic            head_mis_s;

    // State and registered outputs with their next values
    dmem_state_e     state_r,    state_s;
    logic            ack_r,      ack_s;
    logic [XLEN-1:0] q_r,        q_s;
    logic            mis_r,      mis_s;
    logic            pf_r,       pf_s;
    logic            ovf_r,      ovf_s;
    logic [XLEN-1:0] haddr_r,    haddr_s;
    logic [XLEN-1:0] hwdata_r,   hwdata_s;
    logic            hwrite_r,   hwrite_s;
    logic [2:0]      hsize_r,    hsize_s;
    logic [1:0]      htrans_r,   htrans_s;
    logic [XLEN-1:0] wdata_lat_r, wdata_lat_s;
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
    logic            store_err_r, store_err_s;
`endif

    assign q_push_data_s = {dmem_adr, dmem_d, dmem_we, dmem_size};
    assign head_adr_s    = q_head_s[QW-1 -: XLEN];
    assign head_d_s      = q_head_s[XLEN+3 -: XLEN];
    assign head_we_s     = q_head_s[3];
    assign head_size_s   = q_head_s[2:0];
    assign head_mis_s    = dmem_misaligned_f(head_size_s, head_adr_s[2:0], (XLEN == 32));

    riscv_dmem_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .push      (dmem_req),
        .pop       (q_pop_s),
        .push_data (q_push_data_s),
        .head_data (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    // Next-state and next-output logic; response outputs default to a zero pulse
    always_comb begin
        state_s     = state_r;
        ack_s       = 1'b0;
        q_s         = {XLEN{1'b0}};
        mis_s       = 1'b0;
        pf_s        = 1'b0;
        haddr_s     = haddr_r;
        hwdata_s    = hwdata_r;
        hwrite_s    = hwrite_r;
        hsize_s     = hsize_r;
        htrans_s    = htrans_r;
        wdata_lat_s = wdata_lat_r;
        q_pop_s     = 1'b0;
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
        store_err_s = store_err_r;
`endif
        case (state_r)
            DMEM_IDLE: begin
                if (!q_empty_s) begin
                    q_pop_s = 1'b1;
                    if (head_mis_s) begin
                        ack_s   = 1'b1;
                        mis_s   = 1'b1;
                        state_s = DMEM_IDLE;
                    end else begin
                        haddr_s     = head_adr_s;
                        hwrite_s    = head_we_s;
                        hsize_s     = head_size_s;
                        htrans_s    = HTRANS_NONSEQ;
                        wdata_lat_s = head_d_s;
                        state_s     = DMEM_ADDR;
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
                        ack_s       = head_we_s;
`endif
                    end
                end else begin
                    state_s = DMEM_IDLE;
                end
            end
            DMEM_ADDR: begin
                if (HREADY) begin
                    htrans_s = HTRANS_IDLE;
                    hwdata_s = wdata_lat_r;
                    state_s  = DMEM_DATA;
                end else begin
                    state_s = DMEM_ADDR;
                end
            end
            DMEM_DATA: begin
                // An error response's first (HREADY=0) cycle is just a wait
                if (HREADY) begin
                    state_s = DMEM_IDLE;
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
                    if (hwrite_r) begin
                        store_err_s = store_err_r | (HRESP == HRESP_ERROR);
                    end else begin
                        ack_s = 1'b1;
                        pf_s  = (HRESP == HRESP_ERROR);
                        q_s   = (HRESP == HRESP_OKAY) ? HRDATA : {XLEN{1'b0}};
                    end
`else
                    ack_s = 1'b1;
                    pf_s  = (HRESP == HRESP_ERROR);
                    q_s   = (!hwrite_r && (HRESP == HRESP_OKAY)) ? HRDATA : {XLEN{1'b0}};
`endif
                end else begin
                    state_s = DMEM_DATA;
                end
            end
            default: begin
                state_s  = DMEM_IDLE;
                htrans_s = HTRANS_IDLE;
            end
        endcase
    end

    // A request that finds the queue full with no pop is dropped and flagged
    assign ovf_s = ovf_r | (dmem_req & q_full_s & ~q_pop_s);

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= DMEM_IDLE;
            ack_r       <= 1'b0;
            q_r         <= {XLEN{1'b0}};
            mis_r       <= 1'b0;
            pf_r        <= 1'b0;
            ovf_r       <= 1'b0;
            haddr_r     <= {XLEN{1'b0}};
            hwdata_r    <= {XLEN{1'b0}};
            hwrite_r    <= 1'b0;
            hsize_r     <= 3'b000;
            htrans_r    <= HTRANS_IDLE;
            wdata_lat_r <= {XLEN{1'b0}};
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
            store_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ack_r       <= ack_s;
            q_r         <= q_s;
            mis_r       <= mis_s;
            pf_r        <= pf_s;
            ovf_r       <= ovf_s;
            haddr_r     <= haddr_s;
            hwdata_r    <= hwdata_s;
            hwrite_r    <= hwrite_s;
            hsize_r     <= hsize_s;
            htrans_r    <= htrans_s;
            wdata_lat_r <= wdata_lat_s;
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
            store_err_r <= store_err_s;
`endif
        end
    end

    assign dmem_ack        = ack_r;
    assign dmem_q          = q_r;
    assign dmem_misaligned = mis_r;
    assign dmem_page_fault = pf_r;
    assign dmem_overflow   = ovf_r;
    assign dmem_busy       = ~q_empty_s | (state_r != DMEM_IDLE) | dmem_req;
`ifdef RISCV_DMEM_EARLY_STORE_ACK_EN
    assign dmem_store_err  = store_err_r;
`endif
    assign HADDR     = haddr_r;
    assign HWDATA    = hwdata_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HTRANS    = htrans_r;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_riscv_dmem_ahb_responder.sv
// Self-checking bench for riscv_dmem_ahb_responder (default build, XLEN=64,
// QUEUE_DEPTH=2). Inputs change on the falling edge, outputs are sampled there.
module tb_riscv_dmem_ahb_responder;
    import riscv_mpsoc_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic            dmem_req;
    logic [XLEN-1:0] dmem_adr;
    logic [XLEN-1:0] dmem_d;
    logic            dmem_we;
    logic [2:0]      dmem_size;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_q;
    logic            dmem_misaligned;
    logic            dmem_page_fault;
    logic            dmem_busy;
    logic            dmem_overflow;
    logic [XLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic [XLEN-1:0] HRDATA;
    logic            HREADY;
    logic            HRESP;

    int tests = 0;
    int fails = 0;

    riscv_dmem_ahb_responder #(.XLEN(XLEN), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .dmem_req(dmem_req), .dmem_adr(dmem_adr), .dmem_d(dmem_d),
        .dmem_we(dmem_we), .dmem_size(dmem_size),
        .dmem_ack(dmem_ack), .dmem_q(dmem_q),
        .dmem_misaligned(dmem_misaligned), .dmem_page_fault(dmem_page_fault),
        .dmem_busy(dmem_busy), .dmem_overflow(dmem_overflow),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference alignment rule: access must sit on a multiple of its byte size
    function automatic logic ref_misaligned(input logic [2:0] size, input logic [63:0] adr);
        int bytes;
        if (size > 3'd3) return 1'b1;
        if (size == 3'd3 && XLEN == 32) return 1'b1;
        bytes = 1 << size;
        return (adr % bytes) != 0;
    endfunction

    // One isolated request with a behavioural slave: waits wait states in the
    // data phase, an error response if err (two-cycle ERROR), rdata on the bus
    task automatic transact(input string tag, input logic [63:0] adr, input logic [63:0] d,
                            input logic we, input logic [2:0] size, input int waits,
                            input logic err, input logic [63:0] rdata);
        logic        mis;
        logic [63:0] exp_q;
        int          nonseq_at;
        int          ack_at;
        int          phase;
        int          wcnt;
        logic        hw_ok;
        int          n_nonseq;
        mis   = ref_misaligned(size, adr);
        exp_q = (!mis && !we && !err) ? rdata : 64'h0;
        @(negedge clk);
        dmem_req = 1'b1; dmem_adr = adr; dmem_d = d; dmem_we = we; dmem_size = size;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge clk);
        dmem_req = 1'b0;
        nonseq_at = -1; ack_at = -1; phase = 0; wcnt = waits; hw_ok = 1'b1; n_nonseq = 0;
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            if (HTRANS == HTRANS_NONSEQ) n_nonseq++;
            if (dmem_ack) begin
                ack_at = c;
                check({tag, "_q"}, dmem_q, exp_q);
                check({tag, "_mis"}, 64'(dmem_misaligned), 64'(mis));
                check({tag, "_pf"}, 64'(dmem_page_fault), 64'(!mis && err));
            end
            if (phase == 0 && HTRANS == HTRANS_NONSEQ) begin
                nonseq_at = c;
                check({tag, "_haddr"}, HADDR, adr);
                check({tag, "_hwrite"}, 64'(HWRITE), 64'(we));
                check({tag, "_hsize"}, 64'(HSIZE), 64'(size));
                HREADY = 1'b1;
                phase  = 1;
            end else if (phase == 1) begin
                if (we && HWDATA !== d) hw_ok = 1'b0;
                if (wcnt > 0) begin
                    HREADY = 1'b0; HRESP = (err && wcnt == 1); HRDATA = ~rdata; wcnt--;
                end else begin
                    HREADY = 1'b1; HRESP = err; HRDATA = rdata; phase = 2;
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
            end
            if (ack_at < 0) @(negedge clk);
        end
        check({tag, "_ack_cycle"}, 64'(ack_at), mis ? 64'd2 : 64'(4 + waits));
        check({tag, "_nonseq_cycle"}, 64'(nonseq_at), mis ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd2);
        if (!mis) check({tag, "_nonseq_len"}, 64'(n_nonseq), 64'd1);
        if (we && !mis) check({tag, "_hwdata_stable"}, 64'(hw_ok), 64'd1);
        @(negedge clk);
        HREADY = 1'b1; HRESP = 1'b0;
        check({tag, "_ack_pulse"}, 64'(dmem_ack), 64'd0);
        check({tag, "_resp_clear"}, {dmem_q[62:0] | 63'(dmem_misaligned), dmem_page_fault}, 64'd0);
    endtask

    // Free-running slave with HREADY=1: counts acks and notes the first two
    task automatic drain(input int c0, input int budget, output int n_acks,
                         output int first_at, output int second_at);
        n_acks = 0; first_at = -1; second_at = -1;
        HREADY = 1'b1; HRESP = 1'b0;
        for (int c = c0; c < c0 + budget; c++) begin
            if (dmem_ack) begin
                n_acks++;
                if (n_acks == 1) first_at = c;
                if (n_acks == 2) second_at = c;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0]  sz_tab [5];
        int          n, a1, a2;
        logic [63:0] radr;
        logic [2:0]  rsz;
        int          rwaits;
        logic        rerr;
        sz_tab[0] = BYTE; sz_tab[1] = HWORD; sz_tab[2] = WORD; sz_tab[3] = DWORD; sz_tab[4] = UNDEF_SIZE;

        rstn = 1'b0; dmem_req = 1'b0; dmem_adr = 64'h0; dmem_d = 64'h0; dmem_we = 1'b0;
        dmem_size = 3'b000; HRDATA = 64'h0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(dmem_ack), 64'd0);
        check("rst_outs", dmem_q | HADDR | HWDATA, 64'h0);
        check("rst_flags", {58'd0, dmem_misaligned, dmem_page_fault, dmem_busy, dmem_overflow, HWRITE, 1'b0}, 64'd0);
        check("rst_htrans_hsize", {59'd0, HTRANS, HSIZE}, 64'd0);
        check("const_ahb", {54'd0, HBURST, HPROT, HMASTLOCK}, {54'd0, 3'b000, 4'b0001, 1'b0});
        rstn = 1'b1;
        @(negedge clk);

        // Directed cases
        transact("lw", 64'h1000, 64'h0, 1'b0, WORD, 0, 1'b0, 64'hDEADBEEF_00000000);
        transact("sh_mis", 64'h1003, 64'h55AA, 1'b1, HWORD, 0, 1'b0, 64'h0);
        transact("sd_wait", 64'h2000, 64'h1122334455667788, 1'b1, DWORD, 2, 1'b0, 64'hCAFE);
        transact("ld_err", 64'h3000, 64'h0, 1'b0, DWORD, 1, 1'b1, 64'h0123456789ABCDEF);
        transact("undef", 64'h4000, 64'h0, 1'b0, UNDEF_SIZE, 0, 1'b0, 64'h0);

        // Back-to-back aligned loads: acks three cycles apart
        @(negedge clk);
        HRDATA = 64'h0F0F;
        dmem_req = 1'b1; dmem_adr = 64'h5000; dmem_we = 1'b0; dmem_size = DWORD;
        @(negedge clk);
        check("b2b_busy", 64'(dmem_busy), 64'd1);
        dmem_adr = 64'h5008;
        @(negedge clk);
        dmem_req = 1'b0;
        drain(2, 12, n, a1, a2);
        check("b2b_count", 64'(n), 64'd2);
        check("b2b_first", 64'(a1), 64'd4);
        check("b2b_second", 64'(a2), 64'd7);
        check("b2b_idle_busy", 64'(dmem_busy), 64'd0);

        // Overflow: the first request is popped to the bus, two fill the queue,
        // so the fourth consecutive request is the one dropped
        HREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dmem_req = 1'b1; dmem_adr = 64'h6000 + 64'(i * 8); dmem_we = 1'b0; dmem_size = DWORD;
            @(negedge clk);
            if (i == 2) check("ovf_not_yet", 64'(dmem_overflow), 64'd0);
        end
        dmem_req = 1'b0;
        check("ovf_set", 64'(dmem_overflow), 64'd1);
        repeat (3) @(negedge clk);
        check("ovf_hold_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        check("ovf_hold_addr", HADDR, 64'h6000);
        check("ovf_no_ack", 64'(dmem_ack), 64'd0);
        drain(0, 30, n, a1, a2);
        check("ovf_ack_count", 64'(n), 64'd3);
        check("ovf_sticky", 64'(dmem_overflow), 64'd1);
        check("ovf_busy_done", 64'(dmem_busy), 64'd0);

        // Reset during the data phase with a second request queued
        @(negedge clk);
        dmem_req = 1'b1; dmem_adr = 64'h7000; dmem_we = 1'b0; dmem_size = WORD; HREADY = 1'b1;
        @(negedge clk);
        dmem_req = 1'b0;
        @(negedge clk);
        check("rst_mid_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        @(negedge clk);
        HREADY = 1'b0;
        dmem_req = 1'b1; dmem_adr = 64'h7008;
        @(negedge clk);
        dmem_req = 1'b0;
        check("rst_mid_busy", 64'(dmem_busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        check("rst_mid_busy0", 64'(dmem_busy), 64'd0);
        check("rst_mid_ovf0", 64'(dmem_overflow), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        drain(0, 10, n, a1, a2);
        check("rst_mid_no_ack", 64'(n), 64'd0);
        check("rst_mid_empty", 64'(dmem_busy), 64'd0);

        // Randomised isolated requests against the reference rules
        for (int k = 0; k < 24; k++) begin
            rsz  = sz_tab[$urandom_range(0, 4)];
            radr = {32'd0, $urandom} & 64'hFFFF_FFF8;
            if ($urandom_range(0, 1) == 1) radr = radr | 64'($urandom_range(0, 7));
            rerr   = ($urandom_range(0, 4) == 0);
            rwaits = $urandom_range(0, 2);
            if (rerr && rwaits == 0) rwaits = 1;
            transact($sformatf("rnd%0d", k), radr, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     rsz, rwaits, rerr, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
